mem_responder: RTL and testbench
================================

# mem_responder

Memory-side responder for the multicycle CPU's control FSM: services the `mem_read`/`mem_write` strobes that the FSM raises in FETCH/EXECUTE/MEM. It holds a word-addressed storage array, inserts a programmable number of wait states and returns `mem_ready` with registered read data. It sits between the control/datapath and storage, so the FSM can stall on `mem_ready` instead of assuming single-cycle memory.

## Interface
- `ADDR_W`, 8: address width.
- `DATA_W`, 16: data word width.
- `DEPTH`, 256: implemented words. Must be ≤ 2^ADDR_W; addresses ≥ DEPTH are out of range.
- `WAIT_CYCLES`, 2: wait states before access. Range 0..15.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `mem_read`  in  1  read request (pulse or level).
- `mem_write`  in  1  write request (pulse or level).
- `addr`  in  ADDR_W  word address, sampled at accept.
- `wdata`  in  DATA_W  write data, sampled at accept.
- `rdata`  out  DATA_W  registered read data.
- `mem_ready`  out  1  one-cycle completion pulse.
- `busy`  out  1  high from accept until return to IDLE.
- `err`  out  1  one-cycle error flag, coincident with `mem_ready`.

## Operation
- FSM states: IDLE, WAIT, RESP, HOLD.
- **IDLE**
  - If `mem_read | mem_write`, accept: latch `addr`, `wdata` and the op.
  - Load the wait counter with `WAIT_CYCLES`.
  - Go to WAIT, or directly to RESP if `WAIT_CYCLES` = 0.
- **WAIT**: decrement the counter each cycle; at 1, go to RESP. Inputs are ignored while in WAIT.
- **RESP** (one cycle):
  - `mem_ready` = 1.
  - Read: `rdata` = array[latched addr].
  - Write: array[latched addr] ← latched wdata. The array is committed at the edge entering RESP.
  - Next state is HOLD.
- **HOLD**: stay until `mem_read` and `mem_write` are both low, then go to IDLE. A level-held strobe is therefore serviced exactly once. A pulse strobe passes through HOLD in one cycle.
- **Errors**
  - Both strobes high at accept: no array access, `rdata` unchanged, `err` = 1 with `mem_ready`.
  - Out-of-range address: read returns 0, write is dropped, `err` = 1 with `mem_ready`.
- `rdata` holds its last read value through writes and idle periods.
- Address or data changes after accept have no effect.

## Timing
- Reset values: state IDLE, `rdata` = 0, `mem_ready` = 0, `busy` = 0, `err` = 0, counter = 0. Array contents are not reset.
- Latency: accept at edge E; `mem_ready` is high in the cycle following edge E+WAIT_CYCLES+1. For example, with `WAIT_CYCLES` = 2, the strobe is seen at edge 0 and `mem_ready` is high after edge 3.
- `mem_ready` and `err` are exactly one cycle wide and registered, with no combinational path from inputs.
- `busy` rises the cycle after accept and falls when the state returns to IDLE.
- Minimum issue interval with pulse strobes: WAIT_CYCLES+3 cycles (accept, waits, RESP, HOLD).
- A strobe arriving while not in IDLE is neither queued nor lost-signalled. The requester must keep it high until `mem_ready` or reissue it.
- Reset mid-operation: return to IDLE immediately. A pending write that has not reached RESP is not committed.

## Structure
- A shared header/package holds the state encodings (IDLE=2'd0, WAIT=2'd1, RESP=2'd2, HOLD=2'd3) and the default width localparams used by the CPU and this block.
- One sub-module, `mem_array`: synchronous write, registered read, `DEPTH`×`DATA_W`, with no reset.
- The FSM, wait counter, request latches and error logic live in `mem_responder`.

## Test plan
- **Write then read:** reset; write 0x1234 to addr 5 (pulse), then read addr 5 → `mem_ready` after 3 edges each; `rdata` = 0x1234; `err` = 0.
- **Latency sweep:** `WAIT_CYCLES` ∈ {0, 1, 4}; a read accepted at edge E → `mem_ready` exactly at edge E+WAIT_CYCLES+1, one cycle wide.
- **Level-held request:** hold `mem_read` high for 10 cycles → exactly one `mem_ready` pulse; the next request is accepted only after the strobe drops.
- **Errors**
  - Both strobes high → `err` = 1 with `mem_ready`; array and `rdata` unchanged.
  - With `DEPTH` = 200, read addr 250 → `rdata` = 0, `err` = 1.
  - With `DEPTH` = 200, write addr 250 → a subsequent read of every valid address is unchanged.
- **Reset mid-write:** write 0xBEEF to addr 3 over old value 0x0001; assert `rst` during WAIT → outputs return to 0 and state to IDLE; a later read of addr 3 returns 0x0001.
- **Input change after accept:** change `addr`/`wdata` during WAIT → access uses the values latched at accept.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared state encodings, default widths and response classification for the
// multicycle CPU memory responder.
package mem_responder_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 16;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2,
    HOLD = 2'd3
  } state_t;

  // Outcome of a request, decided at the edge that launches the array access.
  typedef struct packed {
    logic rd_ok;
    logic zero;
    logic err;
  } resp_t;

  function automatic resp_t classify(input logic rd, input logic wr, input logic in_range);
    resp_t r;
    r.rd_ok = rd & ~wr & in_range;
    r.zero  = rd & ~wr & ~in_range;
    r.err   = (rd & wr) | ~in_range;
    return r;
  endfunction

endpackage

// File: rtl/mem_responder_array.sv
// Word storage for the responder: synchronous write, registered read.
module mem_array
  import mem_responder_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: storage is deliberately left without reset so it maps onto RAM macros.
  always_ff @(posedge clk) begin
    if (we) mem[addr[IDX_W-1:0]] <= wdata;
    if (re) rdata <= mem[addr[IDX_W-1:0]];
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: accepts read/write strobes, inserts wait states and
// returns a one-cycle mem_ready with registered read data and error flag.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_ready,
  output logic              busy,
  output logic              err
);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              op_rd_q, op_wr_q;
  resp_t             resp_q;

  logic              accept, go_resp, in_range, acc_rd, acc_wr, arr_we, arr_re;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata, arr_rdata;

  assign accept = (state == IDLE) && (mem_read || mem_write);

  // With zero wait states the access launches straight from IDLE, so the live
  // inputs stand in for the not-yet-loaded request latches.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    acc_rd    = op_rd_q;
    acc_wr    = op_wr_q;
    go_resp   = 1'b0;
    case (state)
      IDLE: begin
        acc_addr  = addr;
        acc_wdata = wdata;
        acc_rd    = mem_read;
        acc_wr    = mem_write;
        go_resp   = accept && (WAIT_CYCLES == 0);
      end
      WAIT:    go_resp = (cnt == CNT_W'(1));
      default: go_resp = 1'b0;
    endcase
  end

  assign in_range = (acc_addr <= ADDR_W'(DEPTH - 1));
  assign arr_we   = go_resp && acc_wr && !acc_rd && in_range;
  assign arr_re   = go_resp && acc_rd && !acc_wr && in_range;

  mem_array #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_array (
    .clk  (clk),
    .we   (arr_we),
    .re   (arr_re),
    .addr (acc_addr),
    .wdata(acc_wdata),
    .rdata(arr_rdata)
  );

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      op_rd_q   <= 1'b0;
      op_wr_q   <= 1'b0;
      resp_q    <= '0;
      rdata     <= '0;
      mem_ready <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      mem_ready <= 1'b0;
      err       <= 1'b0;
      if (go_resp) resp_q <= classify(acc_rd, acc_wr, in_range);
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q  <= addr;
            wdata_q <= wdata;
            op_rd_q <= mem_read;
            op_wr_q <= mem_write;
            cnt     <= CNT_W'(WAIT_CYCLES);
            busy    <= 1'b1;
            state   <= (WAIT_CYCLES == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= RESP;
        end
        RESP: begin
          // Registered read data lands here, one edge after the array access.
          mem_ready <= 1'b1;
          err       <= resp_q.err;
          if (resp_q.rd_ok)     rdata <= arr_rdata;
          else if (resp_q.zero) rdata <= '0;
          state <= HOLD;
        end
        HOLD: begin
          if (!mem_read && !mem_write) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder: one instance per wait-state
// setting, instance 0 (WAIT_CYCLES=2, DEPTH=200) carries the functional tests.
module tb_mem_responder;

  localparam int N = 4;
  localparam int WC[N] = '{2, 0, 1, 4};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd      [N];
  logic        wr      [N];
  logic [7:0]  addr_s  [N];
  logic [15:0] wdata_s [N];
  logic [15:0] rdata_s [N];
  logic        ready   [N];
  logic        busy    [N];
  logic        err     [N];

  int n_cmp = 0;
  int n_bad = 0;
  int ready_cnt [N] = '{default: 0};

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    mem_responder #(
      .ADDR_W     (8),
      .DATA_W     (16),
      .DEPTH      (g == 0 ? 200 : 256),
      .WAIT_CYCLES(g == 0 ? 2 : (g == 1 ? 0 : (g == 2 ? 1 : 4)))
    ) dut (
      .clk      (clk),
      .rst      (rst),
      .mem_read (rd[g]),
      .mem_write(wr[g]),
      .addr     (addr_s[g]),
      .wdata    (wdata_s[g]),
      .rdata    (rdata_s[g]),
      .mem_ready(ready[g]),
      .busy     (busy[g]),
      .err      (err[g])
    );
  end

  always @(negedge clk)
    for (int k = 0; k < N; k++) if (ready[k] === 1'b1) ready_cnt[k]++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One pulse request on instance i; optionally scrambles addr/wdata after accept.
  task automatic op(input int i, input logic r, input logic w, input logic [7:0] a,
                    input logic [15:0] d, input bit scramble,
                    input logic [15:0] exp_rd, input logic exp_err, input string tag);
    int lat;
    rd[i] = r; wr[i] = w; addr_s[i] = a; wdata_s[i] = d;
    @(posedge clk); #1;
    rd[i] = 1'b0; wr[i] = 1'b0;
    if (scramble) begin
      addr_s[i]  = ~a;
      wdata_s[i] = ~d;
    end
    check({tag, "_busy_up"}, 32'(busy[i]), 32'd1);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (ready[i] === 1'b1) begin
        lat = n;
        break;
      end
    end
    check({tag, "_latency"}, 32'(lat), 32'(WC[i] + 1));
    check({tag, "_rdata"}, 32'(rdata_s[i]), 32'(exp_rd));
    check({tag, "_err"}, 32'(err[i]), 32'(exp_err));
    @(posedge clk); #1;
    check({tag, "_ready_width"}, 32'(ready[i]), 32'd0);
    check({tag, "_err_width"}, 32'(err[i]), 32'd0);
    check({tag, "_busy_down"}, 32'(busy[i]), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int c0;
    for (int k = 0; k < N; k++) begin
      rd[k] = 1'b0; wr[k] = 1'b0; addr_s[k] = '0; wdata_s[k] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      check($sformatf("reset_rdata%0d", k), 32'(rdata_s[k]), 32'd0);
      check($sformatf("reset_ready%0d", k), 32'(ready[k]), 32'd0);
      check($sformatf("reset_busy%0d", k), 32'(busy[k]), 32'd0);
      check($sformatf("reset_err%0d", k), 32'(err[k]), 32'd0);
    end
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Write then read, both-strobe error.
    op(0, 1'b0, 1'b1, 8'd5, 16'h1234, 1'b0, 16'h0000, 1'b0, "wr5");
    op(0, 1'b1, 1'b0, 8'd5, 16'h0000, 1'b0, 16'h1234, 1'b0, "rd5");
    op(0, 1'b1, 1'b1, 8'd5, 16'hFFFF, 1'b0, 16'h1234, 1'b1, "both");
    op(0, 1'b1, 1'b0, 8'd5, 16'h0000, 1'b0, 16'h1234, 1'b0, "rd5_after_both");

    // Fill every valid word, drop an out-of-range write, read everything back.
    for (int a = 0; a < 200; a++)
      op(0, 1'b0, 1'b1, 8'(a), 16'(a) ^ 16'hA500, 1'b0, 16'h1234, 1'b0, "fill");
    op(0, 1'b0, 1'b1, 8'd250, 16'h5A5A, 1'b0, 16'h1234, 1'b1, "oor_wr");
    for (int a = 0; a < 200; a++)
      op(0, 1'b1, 1'b0, 8'(a), 16'h0000, 1'b0, 16'(a) ^ 16'hA500, 1'b0, "sweep");

    // Reset during WAIT of a write must not commit it.
    op(0, 1'b0, 1'b1, 8'd3, 16'h0001, 1'b0, 16'hA5C7, 1'b0, "wr3_old");
    wr[0] = 1'b1; addr_s[0] = 8'd3; wdata_s[0] = 16'hBEEF;
    @(posedge clk); #1;
    wr[0] = 1'b0;
    @(posedge clk); #1;
    c0 = ready_cnt[0];
    rst = 1'b1;
    #1;
    check("rst_mid_rdata", 32'(rdata_s[0]), 32'd0);
    check("rst_mid_ready", 32'(ready[0]), 32'd0);
    check("rst_mid_busy", 32'(busy[0]), 32'd0);
    check("rst_mid_err", 32'(err[0]), 32'd0);
    @(negedge clk) rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("rst_mid_no_ready", 32'(ready_cnt[0] - c0), 32'd0);
    check("rst_mid_idle_busy", 32'(busy[0]), 32'd0);
    op(0, 1'b1, 1'b0, 8'd3, 16'h0000, 1'b0, 16'h0001, 1'b0, "rd3_after_rst");
    op(0, 1'b1, 1'b0, 8'd250, 16'h0000, 1'b0, 16'h0000, 1'b1, "oor_rd");

    // Inputs changed after accept are ignored.
    op(0, 1'b0, 1'b1, 8'd10, 16'h7777, 1'b1, 16'h0000, 1'b0, "wr_scr");
    op(0, 1'b1, 1'b0, 8'd10, 16'h0000, 1'b1, 16'h7777, 1'b0, "rd_scr");

    // Level-held read is serviced once; HOLD releases only when the strobe drops.
    c0 = ready_cnt[0];
    rd[0] = 1'b1; addr_s[0] = 8'd10;
    repeat (10) @(posedge clk);
    #1;
    check("lvl_busy_held", 32'(busy[0]), 32'd1);
    check("lvl_rdata", 32'(rdata_s[0]), 32'h7777);
    rd[0] = 1'b0;
    @(posedge clk); #1;
    check("lvl_busy_released", 32'(busy[0]), 32'd0);
    check("lvl_pulse_count", 32'(ready_cnt[0] - c0), 32'd1);
    op(0, 1'b1, 1'b0, 8'd5, 16'h0000, 1'b0, 16'hA505, 1'b0, "lvl_next");

    // Latency sweep on the other wait-state settings.
    for (int i = 1; i < N; i++) begin
      op(i, 1'b0, 1'b1, 8'd7, 16'hC0DE + 16'(i), 1'b0, 16'h0000, 1'b0, $sformatf("lat_wr_w%0d", WC[i]));
      op(i, 1'b1, 1'b0, 8'd7, 16'h0000, 1'b0, 16'hC0DE + 16'(i), 1'b0, $sformatf("lat_rd_w%0d", WC[i]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
